// File: rtl/sha_feeder_pkg.sv
// Shared types and constants for the SHA core input feeder.
package sha_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ANNOUNCE = 2'd1,
        RUN      = 2'd2,
        DONE     = 2'd3
    } FeederState;

    localparam int WORK_WORDS      = 12;
    localparam int ANNOUNCE_CYCLES = 4;
    localparam int DIFFICULTY_IDX  = 11;

    typedef logic [WORK_WORDS-1:0][31:0] work_t;

    // Index of the first of the three work words shown in announce cycle k.
    function automatic logic [3:0] announce_base(input logic [1:0] k);
        return 4'(k) * 4'd3;
    endfunction

endpackage

// File: rtl/core_inputs_ifc.sv
// Feeder-to-core link: valid, newblock marker and three 32-bit payload words per cycle.
interface coreInputsIfc;
    logic        valid;
    logic        newblock;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;

    modport writer (output valid, newblock, w1, w2, w3);
    modport reader (input valid, newblock, w1, w2, w3);
endinterface

// File: rtl/sha_feeder_work_buffer.sv
// Shadow work-unit buffer: collects 12 host words while the active unit is being processed.
module sha_feeder_work_buffer
    import sha_feeder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [31:0] host_word,
    input  logic        swap,
    output logic        full,
    output work_t       words
);

    logic [3:0] load_cnt;
    logic       accept;

    assign host_ready = !full;
    assign accept     = host_valid && !full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_cnt <= 4'd0;
            full     <= 1'b0;
        end else if (swap) begin
            full <= 1'b0;
        end else if (accept) begin
            if (load_cnt == 4'(DIFFICULTY_IDX)) begin
                load_cnt <= 4'd0;
                full     <= 1'b1;
            end else begin
                load_cnt <= load_cnt + 4'd1;
            end
        end
    end

    // Payload storage needs no reset; full gates its use.
    always_ff @(posedge clk) begin
        if (accept) begin
            words[load_cnt] <= host_word;
        end
    end

endmodule

// File: rtl/sha_core_input_feeder.sv
// Announces a work unit to one SHA core then streams strided nonces.
// Optional SHA_FEEDER_PAUSE_EN adds a pause input that stalls nonce issue in RUN.
module sha_core_input_feeder
    import sha_feeder_pkg::*;
#(
    parameter int unsigned PROCESSORINDEX = 0,
    parameter int unsigned NUMPROCESSORS  = 1
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         host_valid,
    output logic         host_ready,
    input  logic [31:0]  host_word,
`ifdef SHA_FEEDER_PAUSE_EN
    input  logic         pause,
`endif
    coreInputsIfc.writer out,
    output logic         exhausted,
    output logic [31:0]  nonce_base
);

    localparam logic [32:0] STRIDE      = 33'(NUMPROCESSORS);
    localparam logic [31:0] FIRST_NONCE = 32'(PROCESSORINDEX);

    FeederState  state;
    FeederState  state_next;
    logic [1:0]  ann_cnt;
    logic [3:0]  ann_base;
    logic        shadow_full;
    logic        swap;
    logic        issue;
    logic        run_go;
    work_t       shadow;
    work_t       active;
    logic [31:0] nonce;
    logic [32:0] nonce_sum;

    sha_feeder_work_buffer u_buffer (
        .clk        (clk),
        .rst        (rst),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_word  (host_word),
        .swap       (swap),
        .full       (shadow_full),
        .words      (shadow)
    );

`ifdef SHA_FEEDER_PAUSE_EN
    assign run_go = !pause;
`else
    assign run_go = 1'b1;
`endif

    assign nonce_sum = {1'b0, nonce} + STRIDE;
    assign ann_base  = announce_base(ann_cnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ann_cnt <= 2'd0;
        end else begin
            state   <= state_next;
            ann_cnt <= (state == ANNOUNCE) ? ann_cnt + 2'd1 : 2'd0;
        end
    end

    // A pending unit preempts everything except an announce already in progress.
    always_comb begin
        state_next = state;
        swap       = 1'b0;
        issue      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (shadow_full) begin
                    swap       = 1'b1;
                    state_next = ANNOUNCE;
                end
            end
            ANNOUNCE: begin
                if (ann_cnt == 2'(ANNOUNCE_CYCLES - 1)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (shadow_full) begin
                    swap       = 1'b1;
                    state_next = ANNOUNCE;
                end else if (run_go) begin
                    issue = 1'b1;
                    if (nonce_sum[32]) begin
                        state_next = DONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (swap) begin
            active <= shadow;
        end
        if (state == ANNOUNCE && state_next == RUN) begin
            nonce <= FIRST_NONCE;
        end else if (issue) begin
            nonce <= nonce_sum[31:0];
        end
    end

    always_comb begin
        out.valid    = 1'b0;
        out.newblock = 1'b0;
        out.w1       = 32'd0;
        out.w2       = 32'd0;
        out.w3       = 32'd0;
        nonce_base   = 32'd0;
        exhausted    = 1'b0;
        case (state)
            ANNOUNCE: begin
                out.valid    = 1'b1;
                out.newblock = 1'b1;
                out.w1       = active[ann_base];
                out.w2       = active[ann_base + 4'd1];
                out.w3       = active[ann_base + 4'd2];
            end
            RUN: begin
                out.valid  = run_go;
                out.w1     = nonce;
                out.w3     = active[DIFFICULTY_IDX];
                nonce_base = nonce;
            end
            DONE: begin
                exhausted = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sha_core_input_feeder.sv
// Directed bench: three feeders with different nonce partitions share one host stream.
module tb_sha_core_input_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        host_valid = 1'b0;
    logic [31:0] host_word = 32'd0;
    logic        hr0, hr1, hr2;
    logic        ex0, ex1, ex2;
    logic [31:0] nb0, nb1, nb2;
`ifdef SHA_FEEDER_PAUSE_EN
    logic        pause = 1'b0;
    logic        pause_off = 1'b0;
`endif

    coreInputsIfc i0 ();
    coreInputsIfc i1 ();
    coreInputsIfc i2 ();

    sha_core_input_feeder #(.PROCESSORINDEX(0), .NUMPROCESSORS(1)) dut0 (
        .clk(clk), .rst(rst), .host_valid(host_valid), .host_ready(hr0), .host_word(host_word),
`ifdef SHA_FEEDER_PAUSE_EN
        .pause(pause),
`endif
        .out(i0), .exhausted(ex0), .nonce_base(nb0));

    sha_core_input_feeder #(.PROCESSORINDEX(2), .NUMPROCESSORS(4)) dut1 (
        .clk(clk), .rst(rst), .host_valid(host_valid), .host_ready(hr1), .host_word(host_word),
`ifdef SHA_FEEDER_PAUSE_EN
        .pause(pause_off),
`endif
        .out(i1), .exhausted(ex1), .nonce_base(nb1));

    sha_core_input_feeder #(.PROCESSORINDEX(32'h0FFF_FFFC), .NUMPROCESSORS(32'h1000_0000)) dut2 (
        .clk(clk), .rst(rst), .host_valid(host_valid), .host_ready(hr2), .host_word(host_word),
`ifdef SHA_FEEDER_PAUSE_EN
        .pause(pause_off),
`endif
        .out(i2), .exhausted(ex2), .nonce_base(nb2));

    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic        nbk0;
        logic [31:0] w1_0;
        logic [31:0] w2_0;
        logic [31:0] w3_0;
        logic [31:0] base0;
        logic [31:0] w1_1;
        logic        v2;
        logic [31:0] w1_2;
        logic        ex2;
    } row_t;

    row_t rows [22];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            host_valid = 1'b1;
            host_word  = base + 32'(i);
            tick();
        end
        host_valid = 1'b0;
        host_word  = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            rows[k].v0    = 1'b1;
            rows[k].nbk0  = 1'b1;
            rows[k].w1_0  = 32'h100 + 32'(3 * k);
            rows[k].w2_0  = 32'h101 + 32'(3 * k);
            rows[k].w3_0  = 32'h102 + 32'(3 * k);
            rows[k].base0 = 32'd0;
            rows[k].w1_1  = 32'h100 + 32'(3 * k);
            rows[k].v2    = 1'b1;
            rows[k].w1_2  = 32'h100 + 32'(3 * k);
            rows[k].ex2   = 1'b0;
        end
        for (int k = 4; k < 22; k++) begin
            int j;
            j = k - 4;
            rows[k].v0    = 1'b1;
            rows[k].nbk0  = 1'b0;
            rows[k].w1_0  = 32'(j);
            rows[k].w2_0  = 32'd0;
            rows[k].w3_0  = 32'h10B;
            rows[k].base0 = 32'(j);
            rows[k].w1_1  = 32'd2 + 32'(4 * j);
            if (j <= 15) begin
                rows[k].v2   = 1'b1;
                rows[k].w1_2 = 32'h0FFF_FFFC + 32'(j) * 32'h1000_0000;
                rows[k].ex2  = 1'b0;
            end else begin
                rows[k].v2   = 1'b0;
                rows[k].w1_2 = 32'd0;
                rows[k].ex2  = 1'b1;
            end
        end

        // Reset state
        tick();
        tick();
        chk("reset_out", {i0.valid, i0.newblock, i0.w1, i0.w2, i0.w3, nb0},
            {1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0});
        chk("reset_ctrl", {hr0, ex0, ex2}, {1'b1, 1'b0, 1'b0});
        rst = 1'b1;

        // First unit: idle until the 12th word lands
        load(32'h100, 12);
        chk("loaded_idle", {hr0, i0.valid, i2.valid}, {1'b0, 1'b0, 1'b0});
        for (int k = 0; k < 22; k++) begin
            tick();
            chk($sformatf("row%0d_d0", k), {i0.valid, i0.newblock, i0.w1, i0.w2, i0.w3, nb0},
                {rows[k].v0, rows[k].nbk0, rows[k].w1_0, rows[k].w2_0, rows[k].w3_0, rows[k].base0});
            chk($sformatf("row%0d_d1", k), {i1.w1}, {rows[k].w1_1});
            chk($sformatf("row%0d_d2", k), {i2.valid, i2.w1, ex2},
                {rows[k].v2, rows[k].w1_2, rows[k].ex2});
        end

        // Second unit loaded while d0/d1 run and d2 sits exhausted
        load(32'h200, 12);
        chk("b_loaded", {hr0, i0.valid, i0.newblock, i0.w1, ex2, i2.valid},
            {1'b0, 1'b1, 1'b0, 32'd29, 1'b1, 1'b0});
        tick();
        chk("b_ann0_d0", {i0.valid, i0.newblock, i0.w1, i0.w2, i0.w3},
            {1'b1, 1'b1, 32'h200, 32'h201, 32'h202});
        chk("b_ann0_d2", {i2.newblock, i2.w1, ex2, hr2}, {1'b1, 32'h200, 1'b0, 1'b1});
        tick();
        tick();
        tick();
        chk("b_ann3_d0", {i0.newblock, i0.w1, i0.w2, i0.w3}, {1'b1, 32'h209, 32'h20A, 32'h20B});
        tick();
        chk("b_run0", {i0.newblock, i0.w1, i0.w3, i1.w1, i2.w1},
            {1'b0, 32'd0, 32'h20B, 32'd2, 32'h0FFF_FFFC});

        // Third unit completes exactly when d2 issues its last nonce
        tick();
        tick();
        tick();
        load(32'h300, 12);
        chk("c_last_nonce", {i2.valid, i2.newblock, i2.w1, ex2, hr2},
            {1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0});
        tick();
        chk("c_swap_d2", {i2.valid, i2.newblock, i2.w1, i2.w2, i2.w3, ex2},
            {1'b1, 1'b1, 32'h300, 32'h301, 32'h302, 1'b0});
        chk("c_swap_d0", {i0.newblock, i0.w1}, {1'b1, 32'h300});

        // Reset in the middle of a partial load
        tick();
        load(32'h400, 5);
        chk("d_pre_reset_run", {i0.valid, i0.newblock}, {1'b1, 1'b0});
        rst = 1'b0;
        #1;
        chk("d_reset_out", {i0.valid, i0.newblock, i0.w1, i0.w2, i0.w3, nb0},
            {1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0});
        chk("d_reset_ctrl", {hr0, ex0, i2.valid}, {1'b1, 1'b0, 1'b0});
        tick();
        rst = 1'b1;
        load(32'h500, 12);
        chk("d_reload_full", {hr0, i0.valid}, {1'b0, 1'b0});
        tick();
        chk("d_ann0", {i0.valid, i0.newblock, i0.w1, i0.w2, i0.w3},
            {1'b1, 1'b1, 32'h500, 32'h501, 32'h502});
        tick();
        tick();
        tick();
        chk("d_ann3", {i0.w1, i0.w2, i0.w3}, {32'h509, 32'h50A, 32'h50B});
        tick();
        chk("d_run0", {i0.valid, i0.newblock, i0.w1, i0.w3}, {1'b1, 1'b0, 32'd0, 32'h50B});

`ifdef SHA_FEEDER_PAUSE_EN
        for (int k = 0; k < 7; k++) tick();
        chk("p_at7", {i0.valid, i0.w1}, {1'b1, 32'd7});
        pause = 1'b1;
        #1;
        chk("p_hold0", {i0.valid, i0.w1}, {1'b0, 32'd7});
        tick();
        chk("p_hold1", {i0.valid, i0.w1}, {1'b0, 32'd7});
        tick();
        chk("p_hold2", {i0.valid, i0.w1}, {1'b0, 32'd7});
        pause = 1'b0;
        #1;
        chk("p_resume7", {i0.valid, i0.w1}, {1'b1, 32'd7});
        tick();
        chk("p_resume8", {i0.valid, i0.w1}, {1'b1, 32'd8});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
